// File: rtl/uart_rx_frame_parser_if.sv
// Byte-stream and payload-stream signals between the UART receiver, the frame
// parser and the downstream command sequencer. The parser uses the slave modport.
interface uart_rx_frame_parser_if;
  logic       i_Rx_DV;
  logic [7:0] i_Rx_Byte;
  logic [7:0] o_Cmd;
  logic [7:0] o_Len;
  logic [7:0] o_Data;
  logic       o_Data_Valid;
  logic       o_Data_Last;
  logic       i_Data_Ready;
  logic       o_Err;
  logic [1:0] o_Err_Code;
  logic       o_Drop;

  modport master (
    output i_Rx_DV, i_Rx_Byte, i_Data_Ready,
    input  o_Cmd, o_Len, o_Data, o_Data_Valid, o_Data_Last, o_Err, o_Err_Code, o_Drop
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte, i_Data_Ready,
    output o_Cmd, o_Len, o_Data, o_Data_Valid, o_Data_Last, o_Err, o_Err_Code, o_Drop
  );
endinterface

// File: rtl/uart_rx_frame_parser.sv
// Extracts SYNC/LEN/CMD/payload/CHK frames from a UART byte stream and replays the payload.
// Optional inter-byte timeout enabled by defining UART_FRAME_TIMEOUT_EN.
module uart_rx_frame_parser #(
  parameter int         MAX_PAYLOAD  = 16,
  parameter logic [7:0] SYNC_BYTE    = 8'hA5,
  parameter int         TIMEOUT_CLKS = 8700
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset,
  uart_rx_frame_parser_if.slave  bus
);
  // state   | meaning
  // IDLE    | hunting for SYNC_BYTE
  // LEN     | next byte is payload length
  // CMD     | next byte is command
  // PAYLOAD | storing payload bytes into buffer
  // CHK     | next byte is mod-256 checksum
  // OUTPUT  | replaying buffered payload, input bytes dropped
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LEN     = 3'd1;
  localparam logic [2:0] ST_CMD     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CHK     = 3'd4;
  localparam logic [2:0] ST_OUTPUT  = 3'd5;

  localparam int         IW      = $clog2(MAX_PAYLOAD + 1);
  localparam int         AW      = $clog2(MAX_PAYLOAD);
  localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);

  logic [2:0]    state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [7:0]    sum_q, sum_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          err_q, err_d;
  logic [1:0]    err_code_q, err_code_d;
  logic          drop_q, drop_d;
  logic          wr_en;
  logic [7:0]    buf_mem [MAX_PAYLOAD];

  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       out_active;
  logic       at_last;
  logic       hs;
  logic       timeout;

  assign rx_dv      = bus.i_Rx_DV;
  assign rx_byte    = bus.i_Rx_Byte;
  assign out_active = (state_q == ST_OUTPUT);
  assign at_last    = (8'(idx_q) == (len_q - 8'd1));
  assign hs         = out_active && bus.i_Data_Ready;

`ifdef UART_FRAME_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CLKS);
  logic [TW-1:0] timer_q, timer_d;
  logic          frame_active;

  // Down-counter reloaded by every byte; terminal count only matters mid-frame.
  assign frame_active = (state_q == ST_LEN) || (state_q == ST_CMD) ||
                        (state_q == ST_PAYLOAD) || (state_q == ST_CHK);
  assign timeout      = frame_active && !rx_dv && (timer_q == '0);

  always_comb begin
    timer_d = timer_q;
    if (rx_dv) begin
      timer_d = TW'(TIMEOUT_CLKS - 1);
    end else if (timer_q != '0) begin
      timer_d = timer_q - 1'b1;
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) timer_q <= '0;
    else         timer_q <= timer_d;
  end
`else
  logic timeout_unused;
  assign timeout        = 1'b0;
  assign timeout_unused = (TIMEOUT_CLKS > 0);
`endif

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    cmd_d      = cmd_q;
    sum_d      = sum_q;
    idx_d      = idx_q;
    err_d      = 1'b0;
    err_code_d = err_code_q;
    drop_d     = out_active && rx_dv;
    wr_en      = 1'b0;
    if (timeout) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = 2'b11;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_dv && (rx_byte == SYNC_BYTE)) state_d = ST_LEN;
        end
        ST_LEN: begin
          if (rx_dv) begin
            if ((rx_byte == 8'd0) || (rx_byte > MAX_LEN)) begin
              state_d    = ST_IDLE;
              err_d      = 1'b1;
              err_code_d = 2'b01;
            end else begin
              len_d   = rx_byte;
              sum_d   = rx_byte;
              state_d = ST_CMD;
            end
          end
        end
        ST_CMD: begin
          if (rx_dv) begin
            cmd_d   = rx_byte;
            sum_d   = sum_q + rx_byte;
            idx_d   = '0;
            state_d = ST_PAYLOAD;
          end
        end
        ST_PAYLOAD: begin
          if (rx_dv) begin
            wr_en = 1'b1;
            sum_d = sum_q + rx_byte;
            idx_d = idx_q + 1'b1;
            if (at_last) state_d = ST_CHK;
          end
        end
        ST_CHK: begin
          if (rx_dv) begin
            if (rx_byte == sum_q) begin
              idx_d   = '0;
              state_d = ST_OUTPUT;
            end else begin
              state_d    = ST_IDLE;
              err_d      = 1'b1;
              err_code_d = 2'b10;
            end
          end
        end
        ST_OUTPUT: begin
          if (hs) begin
            if (at_last) state_d = ST_IDLE;
            else         idx_d   = idx_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q    <= ST_IDLE;
      len_q      <= '0;
      cmd_q      <= '0;
      sum_q      <= '0;
      idx_q      <= '0;
      err_q      <= 1'b0;
      err_code_q <= 2'b00;
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      cmd_q      <= cmd_d;
      sum_q      <= sum_d;
      idx_q      <= idx_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      drop_q     <= drop_d;
    end
  end

  // Payload storage needs no reset; it is only read after being written.
  always_ff @(posedge i_Clock) begin
    if (wr_en) buf_mem[idx_q[AW-1:0]] <= rx_byte;
  end

  assign bus.o_Cmd        = out_active ? cmd_q : 8'd0;
  assign bus.o_Len        = out_active ? len_q : 8'd0;
  assign bus.o_Data       = out_active ? buf_mem[idx_q[AW-1:0]] : 8'd0;
  assign bus.o_Data_Valid = out_active;
  assign bus.o_Data_Last  = out_active && at_last;
  assign bus.o_Err        = err_q;
  assign bus.o_Err_Code   = err_code_q;
  assign bus.o_Drop       = drop_q;
endmodule

// File: tb/tb_uart_rx_frame_parser.sv
// Scoreboard bench for uart_rx_frame_parser: expected payload bytes and error codes
// are queued as frames are sent and retired as the parser produces them.
module tb_uart_rx_frame_parser;
  localparam int TO_CLKS = 8700;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_frame_parser_if bus();

  uart_rx_frame_parser dut (
    .i_Clock (clk),
    .i_Reset (rst),
    .bus     (bus)
  );

  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] len;
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t       exp_data[$];
  logic [1:0] exp_err[$];
  logic [7:0] pl_q[$];
  int         n_total  = 0;
  int         n_bad    = 0;
  int         drop_cnt = 0;
  int         drop_exp = 0;
  bit         rdy_rand = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.o_Data_Valid) begin
        if (exp_data.size() == 0) begin
          chk("unexp_valid", 32'(bus.o_Data_Valid), 32'd0);
        end else begin
          e = exp_data[0];
          chk("data", 32'(bus.o_Data), 32'(e.data));
          chk("last", 32'(bus.o_Data_Last), 32'(e.last));
          chk("cmd", 32'(bus.o_Cmd), 32'(e.cmd));
          chk("len", 32'(bus.o_Len), 32'(e.len));
          if (bus.i_Data_Ready) void'(exp_data.pop_front());
        end
      end
      if (bus.o_Err) begin
        if (exp_err.size() == 0) chk("unexp_err", 32'(bus.o_Err_Code), 32'd0);
        else                     chk("err_code", 32'(bus.o_Err_Code), 32'(exp_err.pop_front()));
      end
      if (bus.o_Drop) drop_cnt++;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(posedge clk); #1;
    bus.i_Rx_DV   = 1'b0;
    @(posedge clk); #1;
  endtask

  // Sends SYNC, LEN, CMD, pl_q, CHK; a nonzero chk_xor corrupts the checksum.
  task automatic send_frame(input logic [7:0] cmd, input logic [7:0] chk_xor, input int gap);
    logic [7:0] len;
    logic [7:0] sum;
    len = 8'(pl_q.size());
    sum = len + cmd;
    foreach (pl_q[i]) sum += pl_q[i];
    if (chk_xor == 8'd0) begin
      foreach (pl_q[i])
        exp_data.push_back('{cmd: cmd, len: len, data: pl_q[i], last: (i == pl_q.size() - 1)});
    end else begin
      exp_err.push_back(2'b10);
    end
    send_byte(8'hA5);
    send_byte(len);
    repeat (gap) begin @(posedge clk); #1; end
    send_byte(cmd);
    foreach (pl_q[i]) send_byte(pl_q[i]);
    send_byte(sum ^ chk_xor);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_data.size() != 0 || exp_err.size() != 0) && n < 500) begin
      if (rdy_rand) bus.i_Data_Ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    chk("drain", 32'(exp_data.size() + exp_err.size()), 32'd0);
    bus.i_Data_Ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
  endtask

  initial begin
    bus.i_Rx_DV      = 1'b0;
    bus.i_Rx_Byte    = 8'd0;
    bus.i_Data_Ready = 1'b1;
    #12;
    chk("rst_valid", 32'(bus.o_Data_Valid), 32'd0);
    chk("rst_cmd", 32'(bus.o_Cmd), 32'd0);
    chk("rst_len", 32'(bus.o_Len), 32'd0);
    chk("rst_data", 32'(bus.o_Data), 32'd0);
    chk("rst_last", 32'(bus.o_Data_Last), 32'd0);
    chk("rst_err", 32'(bus.o_Err), 32'd0);
    chk("rst_code", 32'(bus.o_Err_Code), 32'd0);
    chk("rst_drop", 32'(bus.o_Drop), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Reference frame, then the same frame with CHK 78, then good again
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'h00, 0);
    drain();
    send_frame(8'h10, 8'h01, 0);
    drain();
    send_frame(8'h10, 8'h00, 0);
    drain();

    // Noise outside a frame is silent; LEN 0 and LEN 17 are rejected
    exp_err.push_back(2'b01);
    exp_err.push_back(2'b01);
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'hA5);
    send_byte(8'h11);
    drain();

    // Stall five cycles on the second payload byte with a byte dropped meanwhile
    send_frame(8'h10, 8'h00, 0);
    bus.i_Data_Ready = 1'b0;
    send_byte(8'h5A);
    drop_exp++;
    repeat (3) begin @(posedge clk); #1; end
    bus.i_Data_Ready = 1'b1;
    drain();

    // LEN=1 with a SYNC-valued byte arriving on the final handshake cycle
    pl_q = '{8'h42};
    bus.i_Data_Ready = 1'b0;
    send_frame(8'h07, 8'h00, 0);
    bus.i_Data_Ready = 1'b1;
    bus.i_Rx_DV      = 1'b1;
    bus.i_Rx_Byte    = 8'hA5;
    @(posedge clk); #1;
    bus.i_Rx_DV = 1'b0;
    drop_exp++;
    drain();

    // LEN=16 with SYNC values inside the payload
    pl_q = {};
    for (int i = 0; i < 16; i++) pl_q.push_back((i % 5 == 0) ? 8'hA5 : 8'(i * 17));
    send_frame(8'hC3, 8'h00, 0);
    drain();

    // Random frames with random backpressure
    rdy_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      pl_q = {};
      for (int i = 0; i < int'($urandom_range(1, 16)); i++) pl_q.push_back(8'($urandom));
      send_frame(8'($urandom), 8'h00, 0);
      drain();
    end
    rdy_rand = 1'b0;

    // Asynchronous reset mid-PAYLOAD
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h10);
    send_byte(8'h11);
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_valid", 32'(bus.o_Data_Valid), 32'd0);
    chk("mid_rst_code", 32'(bus.o_Err_Code), 32'd0);
    chk("mid_rst_err", 32'(bus.o_Err), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    pl_q = '{8'h11, 8'h22, 8'h33};
    send_frame(8'h10, 8'h00, 0);
    drain();

`ifdef UART_FRAME_TIMEOUT_EN
    exp_err.push_back(2'b11);
    send_byte(8'hA5);
    send_byte(8'h02);
    repeat (TO_CLKS + 5) begin @(posedge clk); #1; end
    drain();
    pl_q = '{8'h01, 8'h02};
    send_frame(8'h20, 8'h00, TO_CLKS - 2);
    drain();
`else
    pl_q = '{8'h01, 8'h02};
    send_frame(8'h20, 8'h00, TO_CLKS + 5);
    drain();
`endif

    chk("drop_count", 32'(drop_cnt), 32'(drop_exp));
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
